clk_reset_seq: RTL and testbench

- Sits directly downstream of the free-running testbench clock generator and consumes its `clk`.
- Produces a stretched, synchronous reset (`rst_out`) for all downstream DUT logic.
- Signals `ready` once the reset-release settle window has passed.
- Generates a programmable periodic single-cycle `tick` strobe and a saturating run-cycle counter used by HW benches for timing and timeouts.

---
 rtl/clk_reset_seq.sv | 138 +++++++++++++
 tb/tb_clk_reset_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : clk_reset_seq
// Purpose  : Reset sequencer for downstream logic. Stretches the master reset,
//            waits a settle window, then enters RUN. In RUN it provides a
//            programmable periodic tick strobe and a saturating cycle counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock from the clock generator
//   reset        in   synchronous active-high master reset (highest priority)
//   soft_rst_req in   synchronous request to re-run the reset sequence
//   tick_en      in   enables the tick divider while in RUN
//   div          in   tick divisor, tick period = div+1 enabled RUN cycles
//   rst_out      out  stretched synchronous reset, active-high
//   ready        out  high only in RUN
//   tick         out  one-cycle strobe every div+1 enabled RUN cycles
//   cycle_count  out  RUN cycles elapsed, saturating at all-ones
// ============================================================================
module clk_reset_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int DIV_W         = 8,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_rst_req,
    input  logic             tick_en,
    input  logic [DIV_W-1:0] div,
    output logic             rst_out,
    output logic             ready,
    output logic             tick,
    output logic [CNT_W-1:0] cycle_count
);

    // Counter widths: enough bits to hold 0..PARAM-1, never narrower than 1.
    localparam int HOLD_W   = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]   c_HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] c_SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [DIV_W-1:0]    r_div_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_HOLD;
            r_hold_cnt   <= '0;
            r_settle_cnt <= '0;
            r_div_cnt    <= '0;
            r_div_q      <= '0;
            rst_out      <= 1'b1;
            ready        <= 1'b0;
            tick         <= 1'b0;
            cycle_count  <= '0;
        end else if (soft_rst_req) begin
            // Restart the stretch from zero in any state; in HOLD this simply
            // extends the reset. A coincident tick boundary is suppressed.
            r_state      <= S_HOLD;
            r_hold_cnt   <= '0;
            r_settle_cnt <= '0;
            rst_out      <= 1'b1;
            ready        <= 1'b0;
            tick         <= 1'b0;
            cycle_count  <= '0;
        end else begin
            tick <= 1'b0;
            case (r_state)
                S_HOLD: begin
                    rst_out <= 1'b1;
                    ready   <= 1'b0;
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state      <= S_SETTLE;
                        r_hold_cnt   <= '0;
                        r_settle_cnt <= '0;
                        rst_out      <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                S_SETTLE: begin
                    rst_out <= 1'b0;
                    ready   <= 1'b0;
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_state      <= S_RUN;
                        r_settle_cnt <= '0;
                        r_div_q      <= div;
                        r_div_cnt    <= '0;
                        ready        <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    rst_out <= 1'b0;
                    ready   <= 1'b1;
                    if (cycle_count != c_CNT_MAX) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    // Divisor is re-sampled only at a tick boundary so a new
                    // value never truncates or stretches the current period.
                    if (tick_en) begin
                        if (r_div_cnt == r_div_q) begin
                            tick      <= 1'b1;
                            r_div_cnt <= '0;
                            r_div_q   <= div;
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state    <= S_HOLD;
                    r_hold_cnt <= '0;
                    rst_out    <= 1'b1;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_reset_seq
// Purpose  : Directed self-checking bench for clk_reset_seq. Inputs change and
//            outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_reset_seq;

    logic        clk;
    logic        reset;
    logic        soft_rst_req;
    logic        tick_en;
    logic [7:0]  div;
    logic        rst_out;
    logic        ready;
    logic        tick;
    logic [31:0] cycle_count;

    logic        s_reset;
    logic        s_soft_rst_req;
    logic        s_tick_en;
    logic [7:0]  s_div;
    logic        s_rst_out;
    logic        s_ready;
    logic        s_tick;
    logic [3:0]  s_cycle_count;

    int n_tests;
    int n_fail;

    clk_reset_seq u_dut (
        .clk          (clk),
        .reset        (reset),
        .soft_rst_req (soft_rst_req),
        .tick_en      (tick_en),
        .div          (div),
        .rst_out      (rst_out),
        .ready        (ready),
        .tick         (tick),
        .cycle_count  (cycle_count)
    );

    clk_reset_seq #(.CNT_W(4)) u_sat (
        .clk          (clk),
        .reset        (s_reset),
        .soft_rst_req (s_soft_rst_req),
        .tick_en      (s_tick_en),
        .div          (s_div),
        .rst_out      (s_rst_out),
        .ready        (s_ready),
        .tick         (s_tick),
        .cycle_count  (s_cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // After reset is released (or soft reset taken) on edge 0, edges 1..15
    // keep rst_out high, edge 16 drops it, edge 18 raises ready.
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL reset_rst_out got %b want 1", rst_out); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
        n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cycle_count); end
        reset = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            n_tests++; if (rst_out !== (k < 16)) begin n_fail++; $display("FAIL seq_rst_out edge %0d got %b want %b", k, rst_out, (k < 16)); end
            n_tests++; if (ready !== (k >= 18)) begin n_fail++; $display("FAIL seq_ready edge %0d got %b want %b", k, ready, (k >= 18)); end
            n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL seq_tick edge %0d got %b want 0", k, tick); end
        end
        n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL ready_rise_count got %0d want 0", cycle_count); end
        for (int k = 19; k <= 23; k++) begin
            @(negedge clk);
            n_tests++; if (tick !== (k == 22)) begin n_fail++; $display("FAIL first_tick edge %0d got %b want %b", k, tick, (k == 22)); end
        end
        n_tests++; if (cycle_count !== 32'd5) begin n_fail++; $display("FAIL count_after5 got %0d want 5", cycle_count); end
    endtask

    // div=3: divider at 1 after edge 23, so ticks on every i with i%4==3.
    task automatic test_tick_period();
        int pulses;
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tick === 1'b1) pulses++;
            n_tests++; if (tick !== ((i % 4) == 3)) begin n_fail++; $display("FAIL tick_div3 cycle %0d got %b want %b", i, tick, ((i % 4) == 3)); end
        end
        n_tests++; if (pulses !== 10) begin n_fail++; $display("FAIL tick_div3_pulses got %0d want 10", pulses); end
        n_tests++; if (cycle_count !== 32'd45) begin n_fail++; $display("FAIL count_after45 got %0d want 45", cycle_count); end
    endtask

    // Divider sits at 1 of a 4-period when div switches to 1.
    task automatic test_div_change();
        div = 8'd1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_tests++; if (tick !== (i >= 3 && (i % 2) == 1)) begin n_fail++; $display("FAIL div_change cycle %0d got %b want %b", i, tick, (i >= 3 && (i % 2) == 1)); end
        end
        tick_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL tick_disabled cycle %0d got %b want 0", i, tick); end
        end
        n_tests++; if (cycle_count !== 32'd58) begin n_fail++; $display("FAIL count_while_disabled got %0d want 58", cycle_count); end
        tick_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_tests++; if (tick !== ((i % 2) == 1)) begin n_fail++; $display("FAIL tick_resume cycle %0d got %b want %b", i, tick, ((i % 2) == 1)); end
        end
    endtask

    task automatic test_soft_reset();
        div = 8'd3;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (38) @(negedge clk);
        n_tests++; if (cycle_count !== 32'd20) begin n_fail++; $display("FAIL soft_pre_count got %0d want 20", cycle_count); end
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL soft_rst_out got %b want 1", rst_out); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL soft_ready got %b want 0", ready); end
        n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL soft_count got %0d want 0", cycle_count); end
        n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL soft_tick got %b want 0", tick); end
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            n_tests++; if (rst_out !== (k < 16)) begin n_fail++; $display("FAIL soft_seq_rst_out edge %0d got %b want %b", k, rst_out, (k < 16)); end
            n_tests++; if (ready !== (k >= 18)) begin n_fail++; $display("FAIL soft_seq_ready edge %0d got %b want %b", k, ready, (k >= 18)); end
        end
        // Soft request in HOLD with hold_cnt=10 restarts the stretch.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL hold_soft_rst_out got %b want 1", rst_out); end
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            n_tests++; if (rst_out !== (k < 16)) begin n_fail++; $display("FAIL hold_soft_rst_out edge %0d got %b want %b", k, rst_out, (k < 16)); end
            n_tests++; if (ready !== (k >= 18)) begin n_fail++; $display("FAIL hold_soft_ready edge %0d got %b want %b", k, ready, (k >= 18)); end
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (16) @(negedge clk);
        // Now in SETTLE: rst_out low, ready low.
        n_tests++; if (rst_out !== 1'b0) begin n_fail++; $display("FAIL settle_rst_out got %b want 0", rst_out); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL settle_reset_rst_out got %b want 1", rst_out); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL settle_reset_ready got %b want 0", ready); end
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            n_tests++; if (rst_out !== (k < 16)) begin n_fail++; $display("FAIL settle_seq_rst_out edge %0d got %b want %b", k, rst_out, (k < 16)); end
            n_tests++; if (ready !== (k >= 18)) begin n_fail++; $display("FAIL settle_seq_ready edge %0d got %b want %b", k, ready, (k >= 18)); end
        end
        repeat (7) @(negedge clk);
        n_tests++; if (cycle_count !== 32'd7) begin n_fail++; $display("FAIL run_pre_count got %0d want 7", cycle_count); end
        reset = 1'b1;
        soft_rst_req = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        soft_rst_req = 1'b0;
        n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL both_rst_out got %b want 1", rst_out); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL both_ready got %b want 0", ready); end
        n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL both_tick got %b want 0", tick); end
        n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL both_count got %0d want 0", cycle_count); end
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            n_tests++; if (rst_out !== (k < 16)) begin n_fail++; $display("FAIL both_seq_rst_out edge %0d got %b want %b", k, rst_out, (k < 16)); end
            n_tests++; if (ready !== (k >= 18)) begin n_fail++; $display("FAIL both_seq_ready edge %0d got %b want %b", k, ready, (k >= 18)); end
            n_tests++; if (tick !== (k == 22)) begin n_fail++; $display("FAIL both_seq_tick edge %0d got %b want %b", k, tick, (k == 22)); end
        end
        n_tests++; if (cycle_count !== 32'd5) begin n_fail++; $display("FAIL both_count_after5 got %0d want 5", cycle_count); end
    endtask

    // 4-bit counter instance with div=0.
    task automatic test_saturate();
        s_reset = 1'b0;
        repeat (18) @(negedge clk);
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready got %b want 1", s_ready); end
        n_tests++; if (s_cycle_count !== 4'd0) begin n_fail++; $display("FAIL sat_start got %0d want 0", s_cycle_count); end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n_tests++; if (s_cycle_count !== ((i > 15) ? 4'd15 : 4'(i))) begin n_fail++; $display("FAIL sat_count cycle %0d got %0d want %0d", i, s_cycle_count, (i > 15) ? 15 : i); end
            n_tests++; if (s_tick !== 1'b1) begin n_fail++; $display("FAIL sat_tick_div0 cycle %0d got %b want 1", i, s_tick); end
        end
        s_tick_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_tests++; if (s_tick !== 1'b0) begin n_fail++; $display("FAIL sat_tick_off got %b want 0", s_tick); end
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b1;
        soft_rst_req   = 1'b0;
        tick_en        = 1'b1;
        div            = 8'd3;
        s_reset        = 1'b1;
        s_soft_rst_req = 1'b0;
        s_tick_en      = 1'b1;
        s_div          = 8'd0;

        test_reset();
        test_tick_period();
        test_div_change();
        test_soft_reset();
        test_mid_reset();
        test_saturate();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
